// File: rtl/opsum_wb_pkg.sv
// Shared types and constants for the opsum writeback stage: FSM states,
// lane/word geometry and the signed 8-bit saturation limits.
package opsum_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int WB_OUT_BITS  = 8;
  localparam int WB_PACK      = 4;
  localparam int WB_WORD_BITS = WB_OUT_BITS * WB_PACK;

  localparam int SAT_MAX = (1 << (WB_OUT_BITS - 1)) - 1;
  localparam int SAT_MIN = -(1 << (WB_OUT_BITS - 1));

endpackage

// File: rtl/opsum_requant.sv
// Combinational requantizer: round-half-up arithmetic shift, optional ReLU
// (enabled by defining OPSUM_WB_RELU_EN), then saturation to OUT_BITS.
module opsum_requant
  import opsum_wb_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int OUT_BITS  = WB_OUT_BITS
) (
  input  logic signed [DATA_SIZE-1:0] x,
  input  logic        [4:0]           shift,
  output logic signed [OUT_BITS-1:0]  y
);

  localparam int EXT_W = DATA_SIZE + 1;

  // One guard bit above the input keeps the rounding add from overflowing.
  function automatic logic signed [EXT_W-1:0] round_shift(
    input logic signed [DATA_SIZE-1:0] v,
    input logic        [4:0]           sh
  );
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    ext = EXT_W'(v);
    if (sh == 5'd0) return ext;
    rnd = EXT_W'(1) <<< (sh - 5'd1);
    return (ext + rnd) >>> sh;
  endfunction

  function automatic logic signed [EXT_W-1:0] relu(input logic signed [EXT_W-1:0] v);
`ifdef OPSUM_WB_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic signed [OUT_BITS-1:0] saturate(input logic signed [EXT_W-1:0] v);
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    hi = EXT_W'(SAT_MAX);
    lo = EXT_W'(SAT_MIN);
    if (v > hi) return OUT_BITS'(SAT_MAX);
    if (v < lo) return OUT_BITS'(SAT_MIN);
    return v[OUT_BITS-1:0];
  endfunction

  assign y = saturate(relu(round_shift(x, shift)));

endmodule

// File: rtl/opsum_writeback.sv
// Requantizes the GLB-bound opsum stream, packs PACK results per word and
// writes them to consecutive GLB addresses. ReLU option: OPSUM_WB_RELU_EN.
module opsum_writeback
  import opsum_wb_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int OUT_BITS  = WB_OUT_BITS,
  parameter int PACK      = WB_PACK,
  parameter int ADDR_BITS = 32,
  parameter int CNT_BITS  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_BITS-1:0]          base_addr,
  input  logic [CNT_BITS-1:0]           num_opsum,
  input  logic [4:0]                    shift,
  input  logic                          opsum_valid,
  output logic                          opsum_ready,
  input  logic signed [DATA_SIZE-1:0]   opsum_data,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ADDR_BITS-1:0]          wr_addr,
  output logic [OUT_BITS*PACK-1:0]      wr_data,
  output logic [PACK-1:0]               wr_strb,
  output logic                          busy,
  output logic                          done
);

  localparam int WORD_BITS = OUT_BITS * PACK;
  localparam int LANE_BITS = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(PACK - 1);

  state_t                     state, state_nxt;
  logic [CNT_BITS-1:0]        remaining;
  logic [LANE_BITS-1:0]       lane_cnt;
  logic [4:0]                 shift_q;
  logic [ADDR_BITS-1:0]       cur_addr;
  logic                       flush_pend;
  logic [WORD_BITS-1:0]       pack_q, pack_nxt, load_data;
  logic [PACK-1:0]            load_strb;
  logic signed [OUT_BITS-1:0] q_val;
  logic take, last_lane, last_opsum, out_free;
  logic load_full, load_part_run, load_part_flush, load;

  function automatic logic [PACK-1:0] strb_mask(input logic [LANE_BITS:0] n);
    logic [PACK-1:0] m;
    for (int k = 0; k < PACK; k++) m[k] = (k < int'(n));
    return m;
  endfunction

  opsum_requant #(.DATA_SIZE(DATA_SIZE), .OUT_BITS(OUT_BITS)) u_requant (
    .x     (opsum_data),
    .shift (shift_q),
    .y     (q_val)
  );

  assign last_lane   = (lane_cnt == LAST_LANE);
  assign last_opsum  = (remaining == CNT_BITS'(1));
  assign out_free    = !wr_valid || wr_ready;
  assign opsum_ready = (state == S_RUN) && (remaining != '0) && (!last_lane || out_free);
  assign take        = opsum_valid && opsum_ready;

  // A final partial word loads immediately when the output slot is free,
  // otherwise it waits in the pack register until FLUSH can hand it over.
  assign load_full       = take && last_lane;
  assign load_part_run   = take && last_opsum && !last_lane && out_free;
  assign load_part_flush = (state == S_FLUSH) && flush_pend && out_free;
  assign load            = load_full || load_part_run || load_part_flush;

  always_comb begin
    pack_nxt = pack_q;
    if (take) pack_nxt[int'(lane_cnt)*OUT_BITS +: OUT_BITS] = q_val;
  end

  always_comb begin
    load_data = pack_nxt;
    load_strb = '1;
    if (load_part_flush) begin
      load_data = pack_q;
      load_strb = strb_mask({1'b0, lane_cnt});
    end else if (load_part_run) begin
      load_strb = strb_mask({1'b0, lane_cnt} + (LANE_BITS+1)'(1));
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = (num_opsum != '0) ? S_RUN : S_DONE;
      S_RUN:   if (take && last_opsum) state_nxt = S_FLUSH;
      S_FLUSH: if (!flush_pend && out_free) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      remaining  <= '0;
      lane_cnt   <= '0;
      shift_q    <= '0;
      cur_addr   <= '0;
      flush_pend <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_strb    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        remaining  <= num_opsum;
        shift_q    <= shift;
        cur_addr   <= base_addr & ~ADDR_BITS'(3);
        lane_cnt   <= '0;
        flush_pend <= 1'b0;
      end
      if (take) begin
        remaining <= remaining - CNT_BITS'(1);
        lane_cnt  <= last_lane ? '0 : lane_cnt + LANE_BITS'(1);
        if (last_opsum && !last_lane && !out_free) flush_pend <= 1'b1;
      end
      if (load_part_flush) flush_pend <= 1'b0;
      // Drain and refill on the same edge keeps one opsum per cycle flowing.
      if (load) begin
        wr_valid <= 1'b1;
        wr_addr  <= cur_addr;
        wr_data  <= load_data;
        wr_strb  <= load_strb;
        cur_addr <= cur_addr + ADDR_BITS'(4);
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end

  // Lanes beyond a partial word's fill level stay zero because the register
  // is cleared at job start and after every full word.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) pack_q <= '0;
    else if (load_full)           pack_q <= '0;
    else if (take)                pack_q <= pack_nxt;
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_opsum_writeback.sv
// Self-checking bench for opsum_writeback: randomized jobs against a
// behavioural model of requantization, packing and addressing.
module tb_opsum_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_opsum;
  logic [4:0]  shift;
  logic        opsum_valid;
  logic        opsum_ready;
  logic [31:0] opsum_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  int  stim_q[$];
  wr_t exp_q[$];

  opsum_writeback dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_opsum(num_opsum), .shift(shift), .opsum_valid(opsum_valid),
    .opsum_ready(opsum_ready), .opsum_data(opsum_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_requant(input int x, input int sh);
    longint v;
    logic [63:0] r;
    v = x;
    if (sh != 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
`ifdef OPSUM_WB_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    r = v;
    return r[7:0];
  endfunction

  function automatic void build_expected(input int n, input int sh, input logic [31:0] base);
    logic [31:0] addr;
    logic [31:0] word;
    int lanes;
    wr_t w;
    exp_q.delete();
    addr  = {base[31:2], 2'b00};
    word  = 0;
    lanes = 0;
    for (int i = 0; i < n; i++) begin
      word[lanes*8 +: 8] = ref_requant(stim_q[i], sh);
      lanes++;
      if (lanes == 4) begin
        w.addr = addr; w.data = word; w.strb = 4'hF;
        exp_q.push_back(w);
        addr += 4; word = 0; lanes = 0;
      end
    end
    if (lanes > 0) begin
      w.addr = addr; w.data = word; w.strb = 4'((1 << lanes) - 1);
      exp_q.push_back(w);
    end
  endfunction

  // mode 0: always valid/ready; 1: random valid/ready and stray starts;
  // 2: wr_ready held low for the first stall_len cycles, valid always high.
  task automatic run_job(input int n, input int sh, input logic [31:0] base,
                         input int mode, input int stall_len, output logic [31:0] first_data);
    int idx = 0;
    int nwr = 0;
    bit fin = 0;
    bit stalled = 0;
    wr_t held;
    logic exp_rdy;
    build_expected(n, sh, base);
    first_data = 'x;
    @(negedge clk);
    start = 1; base_addr = base; num_opsum = 16'(n); shift = 5'(sh);
    opsum_valid = 0; wr_ready = 1;
    for (int c = 1; c <= 600 && !fin; c++) begin
      @(negedge clk);
      start = 0;
      base_addr = $urandom; num_opsum = 16'($urandom); shift = 5'($urandom);
      case (mode)
        0: begin wr_ready = 1; opsum_valid = (idx < n); end
        1: begin
          wr_ready    = ($urandom_range(0, 3) != 0);
          opsum_valid = (idx < n) && ($urandom_range(0, 3) != 0);
          start       = (idx < n) && ($urandom_range(0, 4) == 0);
        end
        default: begin wr_ready = (c > stall_len); opsum_valid = (idx < n); end
      endcase
      opsum_data = (idx < n) ? stim_q[idx] : $urandom;
      #1;
      exp_rdy = (idx < n) && ((idx % 4) != 3 || !wr_valid || wr_ready);
      checks++;
      if (opsum_ready !== exp_rdy) begin
        errors++;
        $display("FAIL opsum_ready c=%0d idx=%0d: got %b expected %b", c, idx, opsum_ready, exp_rdy);
      end
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", busy); end
      end
      if (stalled) begin
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== held.addr || wr_data !== held.data || wr_strb !== held.strb) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h %h %h expected v=1 %h %h %h",
                   wr_valid, wr_addr, wr_data, wr_strb, held.addr, held.data, held.strb);
        end
      end
      stalled = wr_valid && !wr_ready;
      held.addr = wr_addr; held.data = wr_data; held.strb = wr_strb;
      if (wr_valid && wr_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_write: got addr %h data %h expected no write", wr_addr, wr_data);
        end else begin
          if (nwr == 0) first_data = wr_data;
          if (wr_addr !== exp_q[0].addr || wr_data !== exp_q[0].data || wr_strb !== exp_q[0].strb) begin
            errors++;
            $display("FAIL write%0d: got %h/%h/%h expected %h/%h/%h", nwr, wr_addr, wr_data, wr_strb,
                     exp_q[0].addr, exp_q[0].data, exp_q[0].strb);
          end
          void'(exp_q.pop_front());
        end
        nwr++;
      end
      if (opsum_valid && opsum_ready) idx++;
      if (done) begin
        fin = 1;
        checks++;
        if (exp_q.size() != 0 || idx != n) begin
          errors++;
          $display("FAIL done_early: got pending=%0d accepted=%0d expected pending=0 accepted=%0d",
                   exp_q.size(), idx, n);
        end
        if (mode == 0) begin
          checks++;
          if ((n > 0 && c != n + 2) || (n == 0 && c > 2)) begin
            errors++;
            $display("FAIL done_latency: got cycle %0d expected %0d", c, (n == 0) ? 1 : n + 2);
          end
        end
      end
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL job_timeout: got no done expected done"); end
    start = 0; opsum_valid = 0; wr_ready = 1;
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (opsum_ready !== 0 || wr_valid !== 0 || wr_addr !== 0 || wr_data !== 0 ||
        wr_strb !== 0 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL %s: got rdy=%b v=%b a=%h d=%h s=%h busy=%b done=%b expected all 0", tag,
               opsum_ready, wr_valid, wr_addr, wr_data, wr_strb, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; base_addr = 0; num_opsum = 0; shift = 0;
    opsum_valid = 0; opsum_data = 0; wr_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset_values");
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic();
    logic [31:0] fd;
    stim_q = '{1, 2, 3, 4};
    run_job(4, 0, 32'h0000_0100, 0, 0, fd);
    checks++;
    if (fd !== 32'h0403_0201) begin errors++; $display("FAIL basic_word: got %h expected 04030201", fd); end
  endtask

  task automatic test_rounding();
    logic [31:0] fd;
    stim_q = '{5, 6, 7, 8, 9, 10};
    run_job(6, 2, 32'h0000_0203, 0, 0, fd);
    checks++;
    if (fd !== 32'h0202_0201) begin errors++; $display("FAIL round_word0: got %h expected 02020201", fd); end
  endtask

  task automatic test_saturation();
    logic [31:0] fd;
    logic [31:0] req;
`ifdef OPSUM_WB_RELU_EN
    req = 32'h0000_007F;
`else
    req = 32'h0000_807F;
`endif
    stim_q = '{1000, -1000};
    run_job(2, 0, 32'h0000_0040, 0, 0, fd);
    checks++;
    if (fd !== req) begin errors++; $display("FAIL saturation: got %h expected %h", fd, req); end
  endtask

  task automatic test_backpressure();
    logic [31:0] fd;
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(int'($urandom_range(0, 2000)) - 1000);
    run_job(8, 3, 32'h0000_1000, 2, 10, fd);
  endtask

  task automatic test_zero_count();
    logic [31:0] fd;
    stim_q.delete();
    run_job(0, 0, 32'h0000_0500, 0, 0, fd);
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] fd;
    @(negedge clk);
    start = 1; num_opsum = 4; shift = 0; base_addr = 32'h80; wr_ready = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 0; opsum_valid = 1; opsum_data = 32'(100 + i);
    end
    @(negedge clk);
    opsum_valid = 0;
    rst = 1;
    #1;
    check_reset_values("reset_mid_job");
    @(negedge clk);
    rst = 0;
    stim_q = '{-7, 20, 33, -2};
    run_job(4, 1, 32'h0000_0090, 0, 0, fd);
  endtask

  task automatic test_random_jobs();
    logic [31:0] fd;
    for (int j = 0; j < 10; j++) begin
      int n;
      n = $urandom_range(1, 19);
      stim_q.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 2))
          0: stim_q.push_back(int'($urandom_range(0, 600)) - 300);
          1: stim_q.push_back(int'($urandom));
          default: stim_q.push_back(int'($urandom_range(0, 200000)) - 100000);
        endcase
      end
      run_job(n, $urandom_range(0, 31), $urandom, (j % 3 == 0) ? 0 : 1, 0, fd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_zero_count();
    test_reset_mid_job();
    test_random_jobs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
